// File: rtl/fp_to_int.sv
// bfloat16 to signed int16 converter, truncating toward zero.
// Normal operands are aligned by a one-bit-per-cycle shifter; special operands finish in one cycle.
module fp_to_int (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] opA,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        overflow,
   output logic        inexact,
   output logic        invalid
);

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic              w_sign;
   logic [7:0]        w_exp;
   logic [6:0]        w_mant;
   logic              w_accept;
   logic              w_is_nan;
   logic              w_is_small;
   logic              w_is_exact_min;
   logic              w_is_normal;
   logic [3:0]        w_k;
   logic              w_left;
   logic [3:0]        w_cnt;

   logic [DATA_W-1:0] r_mag;
   logic              r_sign;
   logic              r_left;
   logic [3:0]        r_cnt;
   logic              r_sticky;
   logic [DATA_W-1:0] r_result;
   logic              r_overflow;
   logic              r_inexact;
   logic              r_invalid;

   // Saturated value for Inf and for magnitudes beyond the int16 range.
   function automatic logic [DATA_W-1:0] f_saturate(input logic sign);
      return sign ? 16'h8000 : 16'h7FFF;
   endfunction

   // Two's-complement sign application; 0x8000 only reaches here as the exact -32768.
   function automatic logic [DATA_W-1:0] f_apply_sign(input logic sign,
                                                      input logic [DATA_W-1:0] mag);
      return sign ? (~mag + 16'd1) : mag;
   endfunction

   // Operand decode
   assign w_sign   = opA[15];
   assign w_exp    = opA[14:7];
   assign w_mant   = opA[6:0];
   assign w_accept = in_valid && (r_state == S_IDLE);

   assign w_is_nan       = (w_exp == 8'hFF) && (w_mant != 7'd0);
   assign w_is_small     = (w_exp < 8'd127);
   assign w_is_exact_min = (w_exp == 8'd142) && w_sign && (w_mant == 7'd0);
   assign w_is_normal    = ((w_exp >= 8'd127) && (w_exp <= 8'd141)) || w_is_exact_min;

   // k = exp - 127 only matters for normal operands, where it lies in 0..15.
   assign w_k    = w_exp[3:0] + 4'd1;
   assign w_left = (w_k > 4'd7);
   assign w_cnt  = w_left ? (w_k - 4'd7) : (4'd7 - w_k);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = w_is_normal ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            if (r_cnt == 4'd0) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake outputs
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE:  in_ready  = 1'b1;
         S_DONE:  out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Alignment datapath, not reset: only meaningful after an accept
   always_ff @(posedge clk) begin
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               r_sign <= w_sign;
               r_left <= w_left;
               r_mag  <= {8'd0, 1'b1, w_mant};
            end
         end
         S_SHIFT: begin
            if (r_cnt != 4'd0) begin
               r_mag <= r_left ? (r_mag << 1) : (r_mag >> 1);
            end
         end
         default: r_mag <= r_mag;
      endcase
   end

   // Shift count, sticky, result and flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt      <= 4'd0;
         r_sticky   <= 1'b0;
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_inexact  <= 1'b0;
         r_invalid  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt    <= w_cnt;
                  r_sticky <= 1'b0;
                  if (w_is_nan) begin
                     r_result   <= '0;
                     r_overflow <= 1'b0;
                     r_inexact  <= 1'b0;
                     r_invalid  <= 1'b1;
                  end else if (w_is_small) begin
                     r_result   <= '0;
                     r_overflow <= 1'b0;
                     r_inexact  <= (w_exp != 8'd0) || (w_mant != 7'd0);
                     r_invalid  <= 1'b0;
                  end else if (!w_is_normal) begin
                     r_result   <= f_saturate(w_sign);
                     r_overflow <= 1'b1;
                     r_inexact  <= 1'b0;
                     r_invalid  <= 1'b0;
                  end
               end
            end
            S_SHIFT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
                  if (!r_left) begin
                     r_sticky <= r_sticky | r_mag[0];
                  end
               end else begin
                  r_result   <= f_apply_sign(r_sign, r_mag);
                  r_overflow <= 1'b0;
                  r_inexact  <= r_sticky;
                  r_invalid  <= 1'b0;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign result   = r_result;
   assign overflow = r_overflow;
   assign inexact  = r_inexact;
   assign invalid  = r_invalid;

endmodule

// File: tb/tb_fp_to_int.sv
// Bench for fp_to_int: directed and random bfloat16 operands compared with an arithmetic model.
module tb_fp_to_int;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] opA;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        overflow;
   logic        inexact;
   logic        invalid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_to_int dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opA       (opA),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .inexact   (inexact),
      .invalid   (invalid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Value-level model: scale the significand, truncate, then range-check the signed integer.
   task automatic ref_model(input logic [15:0] op, output logic [15:0] r,
                            output logic ov, output logic ix, output logic iv, output int lat);
      int     e;
      int     mn;
      int     k;
      logic   s;
      longint m;
      longint mag;
      longint v;
      e   = int'(op[14:7]);
      mn  = int'(op[6:0]);
      s   = op[15];
      r   = 16'h0000;
      ov  = 1'b0;
      ix  = 1'b0;
      iv  = 1'b0;
      lat = 1;
      if (e == 255) begin
         if (mn != 0) iv = 1'b1;
         else begin
            ov = 1'b1;
            r  = s ? 16'h8000 : 16'h7FFF;
         end
      end else if (e == 0) begin
         ix = (mn != 0);
      end else begin
         k = e - 127;
         m = longint'(128 + mn);
         if (k < 0) begin
            ix = 1'b1;
         end else if (k > 15) begin
            ov = 1'b1;
            r  = s ? 16'h8000 : 16'h7FFF;
         end else begin
            if (k >= 7) mag = m << (k - 7);
            else begin
               mag = m >> (7 - k);
               ix  = ((mag << (7 - k)) != m);
            end
            v = s ? -mag : mag;
            if (v > 32767 || v < -32768) begin
               ov = 1'b1;
               ix = 1'b0;
               r  = s ? 16'h8000 : 16'h7FFF;
            end else begin
               r   = v[15:0];
               lat = 2 + ((k >= 7) ? (k - 7) : (7 - k));
            end
         end
      end
   endtask

   task automatic convert(input logic [15:0] op, input int hold, input string tag);
      logic [15:0] er;
      logic        eo;
      logic        ex;
      logic        ei;
      int          el;
      int          lat;
      int          guard;
      ref_model(op, er, eo, ex, ei, el);
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      opA       = op;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      opA = 16'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 40);
      check({tag, "_latency"}, 32'(lat), 32'(el));
      check({tag, "_result"}, 32'(result), 32'(er));
      check({tag, "_flags"}, {29'd0, overflow, inexact, invalid}, {29'd0, eo, ex, ei});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold"}, {12'd0, in_ready, out_valid, result, overflow, inexact, invalid},
               {12'd0, 1'b0, 1'b1, er, eo, ex, ei});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_release"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
   endtask

   initial begin
      logic [15:0] rop;
      int          sel;
      int          ex;
      int          mt;
      reset     = 1'b0;
      in_valid  = 1'b0;
      opA       = 16'h0000;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_handshake", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
      check("rst_result", 32'(result), 32'h0);
      check("rst_flags", {29'd0, overflow, inexact, invalid}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      convert(16'h3F80, 0, "one");
      convert(16'h4300, 0, "p128");
      convert(16'hC020, 5, "m2p5_hold");
      convert(16'hC700, 0, "m32768");
      convert(16'h4700, 0, "p32768");
      convert(16'h7FC0, 0, "nan");
      convert(16'hFF80, 2, "minf");
      convert(16'h3F00, 0, "half");
      convert(16'h8000, 0, "negzero");
      convert(16'h0001, 0, "denorm");
      convert(16'h46FF, 0, "maxpos");
      convert(16'hC701, 0, "below_min");

      for (int n = 0; n < 60; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 7)       ex = int'($urandom_range(118, 144));
         else if (sel == 7) ex = 255;
         else if (sel == 8) ex = 0;
         else               ex = int'($urandom_range(0, 255));
         mt  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 127));
         rop = {1'($urandom_range(0, 1)), 8'(ex), 7'(mt)};
         convert(rop, int'($urandom_range(0, 2)), "rand");
      end

      convert(16'hC700, 0, "pre_reset");
      in_valid = 1'b1;
      opA      = 16'h3F80;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_shift_busy", {30'd0, in_ready, out_valid}, {30'd0, 1'b0, 1'b0});
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_handshake", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
      check("mid_rst_result", 32'(result), 32'h0);
      check("mid_rst_flags", {29'd0, overflow, inexact, invalid}, 32'd0);
      sel = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) sel++;
      end
      check("mid_rst_quiet", 32'(sel), 32'd0);
      convert(16'hC020, 0, "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_to_int.md
FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have port in_valid  input  1  operand on opA valid.
REQ-004 SHALL have port in_ready  output  1  block can accept an operand.
REQ-005 SHALL have port opA  input  16  bfloat16 operand: sign [15], biased exponent [14:7] (bias 127), mantissa [6:0].
REQ-006 SHALL have port out_valid  output  1  result and flags valid.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-008 SHALL have port result  output  16  signed two's-complement int16.
REQ-009 SHALL have ports overflow, inexact, invalid  output  1 each  status flags qualified by out_valid.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-011 SHALL capture opA on an accept (in_valid & in_ready) in IDLE. Next state is SHIFT for the normal case and DONE for special cases.
REQ-012 SHALL round toward zero (truncate). Let k = exp-127. Magnitude = floor({1,mant} x 2^(k-7)).
REQ-013 SHALL treat as normal case 0<=k<=14, plus k==15 only when sign=1 and mant=0. SHIFT count N = |k-7|, range 0..8.
REQ-014 SHALL in SHIFT move magnitude one bit per cycle for N cycles: right shift if k<7, with dropped bits ORed into a sticky bit; left shift if k>7. N=0 spends exactly one cycle in SHIFT.
REQ-015 SHALL on leaving SHIFT register: result = sign ? -mag : mag; inexact = sticky; overflow = invalid = 0. Next state is DONE.
REQ-016 SHALL handle exp==255 with mant!=0 (NaN) as: result 0x0000, invalid=1, other flags 0.
REQ-017 SHALL handle exp==255 with mant==0 (Inf) and out-of-range values (k>=15, except exact -32768) as: result 0x7FFF if sign=0 or 0x8000 if sign=1, overflow=1, inexact=0.
REQ-018 SHALL handle exp==0 (zero or denormal, flushed) and 1<=exp<=126 (|x|<1) as: result 0x0000; inexact=1 unless exp==0 and mant==0. Signed zero gives 0x0000.
REQ-019 SHALL give latency from accept cycle T to out_valid: T+1 for special cases and T+2+N for the normal case.
REQ-020 SHALL hold result and flags stable in DONE until out_ready=1. On that cycle it returns to IDLE. No new accept occurs in the same cycle as the result handshake; in_ready rises the following cycle.
REQ-021 SHALL ignore opA and in_valid while not in IDLE.
REQ-022 SHALL use a magnitude datapath of at least 16 bits plus sticky. Negation is two's-complement in 16 bits; -32768 is representable only by the exact case.

Reset
REQ-023 SHALL on reset==0 at a rising edge force state IDLE, result 0x0000, all flags 0, and clear shift count and sticky, regardless of current state.
REQ-024 SHALL drop any in-flight conversion when reset occurs mid-SHIFT or in DONE. After reset deasserts, in_ready=1 and out_valid=0 until a new accept.

Verification
REQ-025 SHALL verify: 0x3F80 (1.0) accepted at T -> out_valid at T+9, result 0x0001, all flags 0.
REQ-026 SHALL verify: 0x4300 (128.0) -> out_valid at T+2, result 0x0080; then 0xC020 (-2.5) -> result 0xFFFE, inexact=1.
REQ-027 SHALL verify: 0xC700 (-32768) -> result 0x8000, no flags, latency T+10; 0x4700 (+32768) -> result 0x7FFF, overflow=1, latency T+1.
REQ-028 SHALL verify: 0x7FC0 (NaN) -> result 0x0000, invalid=1. 0xFF80 (-Inf) -> result 0x8000, overflow=1. 0x3F00 (0.5) -> result 0x0000, inexact=1.
REQ-029 SHALL verify: out_ready held 0 for 5 cycles in DONE -> result and flags unchanged and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-030 SHALL verify: reset=0 asserted mid-SHIFT of 0x3F80 -> next cycle state IDLE, out_valid=0, result 0x0000, in_ready=1.
